// File: rtl/ofdm_frame_sched_pkg.sv
// Shared definitions for the OFDM frame scheduler: state encoding, default
// transform geometry and the cyclic-prefix index mapping.
package ofdm_frame_sched_pkg;

    localparam int N_POINTS_DEF = 8;
    localparam int IDX_W_DEF    = 3;
    localparam int CP_LEN_DEF   = 2;
    localparam int TIMEOUT_DEF  = 64;
    localparam int TO_W_DEF     = 7;
    localparam int FRAME_CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EMIT  = 3'd4
    } state_e;

    // Emit position -> transform-output index: the prefix replays the tail, then 0..N-1.
    function automatic int cp_map(input int e, input int cp_len, input int n_points);
        return (e < cp_len) ? (n_points - cp_len + e) : (e - cp_len);
    endfunction

endpackage

// File: rtl/ofdm_cp_addr_gen.sv
// Readout address generator: walks the cyclic prefix then the full symbol,
// advancing only on downstream handshakes.
module ofdm_cp_addr_gen
    import ofdm_frame_sched_pkg::*;
#(
    parameter int N_POINTS = N_POINTS_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int CP_LEN   = CP_LEN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             active,
    input  logic             out_ready,
    output logic [IDX_W-1:0] rd_idx,
    output logic             out_last,
    output logic             emit_done
);

    localparam int E_LEN = CP_LEN + N_POINTS;
    localparam int E_W   = $clog2(E_LEN);
    localparam logic [E_W-1:0] E_LAST = E_W'(E_LEN - 1);

    logic [E_W-1:0] e_q;
    logic [E_W-1:0] e_d;
    logic           at_last;
    logic           adv;

    always_comb begin
        at_last = (e_q == E_LAST);
        adv     = active & out_ready;
        e_d     = e_q;
        if (clear) begin
            e_d = '0;
        end else if (adv) begin
            e_d = at_last ? '0 : e_q + E_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    // Outputs are forced to zero outside readout so idle values match reset values.
    always_comb begin
        rd_idx    = '0;
        out_last  = 1'b0;
        emit_done = 1'b0;
        if (active) begin
            rd_idx    = IDX_W'(cp_map(int'(e_q), CP_LEN, N_POINTS));
            out_last  = at_last;
            emit_done = adv & at_last;
        end
    end

endmodule

// File: rtl/ofdm_frame_sched.sv
// OFDM symbol scheduler: loads a frame into the collector, kicks the IFFT,
// waits (with timeout) for completion, then reads out with cyclic prefix.
module ofdm_frame_sched
    import ofdm_frame_sched_pkg::*;
#(
    parameter int N_POINTS = N_POINTS_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int CP_LEN   = CP_LEN_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int TO_W     = TO_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   clr_err,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   ld_en,
    output logic [IDX_W-1:0]       ld_idx,
    output logic                   fft_start,
    input  logic                   fft_done,
    output logic [IDX_W-1:0]       rd_idx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   to_err,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       load_cnt_q, load_cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   to_err_q, to_err_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   load_last;
    logic                   to_term;
    logic                   in_wait;
    logic                   timeout_hit;
    logic                   emit_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (ld_en) begin
                    state_d = load_last ? ST_START : ST_LOAD;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                // Completion takes priority over a coincident terminal count.
                if (fft_done) begin
                    state_d = ST_EMIT;
                end else if (to_term) begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (emit_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
        ld_en     = in_valid & in_ready;
        ld_idx    = load_cnt_q;
        fft_start = (state_q == ST_START);
        out_valid = (state_q == ST_EMIT);
        busy      = (state_q != ST_IDLE);
        to_err    = to_err_q;
        frame_cnt = frame_cnt_q;
    end

    always_comb begin
        load_last   = (load_cnt_q == IDX_W'(N_POINTS - 1));
        to_term     = (to_cnt_q == TO_W'(TIMEOUT - 1));
        in_wait     = (state_q == ST_WAIT);
        timeout_hit = in_wait & ~fft_done & to_term & ~flush;

        load_cnt_d = load_cnt_q;
        if (ld_en) begin
            load_cnt_d = load_last ? '0 : load_cnt_q + IDX_W'(1);
        end

        to_cnt_d = '0;
        if (in_wait && !fft_done && !to_term) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        if (flush) begin
            load_cnt_d = '0;
            to_cnt_d   = '0;
        end

        to_err_d = to_err_q;
        if (timeout_hit) begin
            to_err_d = 1'b1;
        end else if (clr_err) begin
            to_err_d = 1'b0;
        end

        frame_cnt_d = frame_cnt_q;
        if (emit_done && !flush) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_cnt_q  <= '0;
            to_cnt_q    <= '0;
            to_err_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            to_cnt_q    <= to_cnt_d;
            to_err_q    <= to_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    ofdm_cp_addr_gen #(
        .N_POINTS (N_POINTS),
        .IDX_W    (IDX_W),
        .CP_LEN   (CP_LEN)
    ) u_cp_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .active    (out_valid),
        .out_ready (out_ready),
        .rd_idx    (rd_idx),
        .out_last  (out_last),
        .emit_done (emit_done)
    );

endmodule

// File: tb/tb_ofdm_frame_sched.sv
// Self-checking bench for ofdm_frame_sched: randomized stimulus against a
// frame-level reference model, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_ofdm_frame_sched;

    localparam int N    = 8;
    localparam int IW   = 3;
    localparam int CP   = 2;
    localparam int TO   = 64;
    localparam int TOW  = 7;
    localparam int ELEN = CP + N;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic clr_err = 1'b0;
    logic in_valid = 1'b0;
    logic fft_done = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, ld_en, fft_start, out_valid, out_last, busy, to_err;
    logic [IW-1:0] ld_idx, rd_idx;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ofdm_frame_sched #(
        .N_POINTS (N), .IDX_W (IW), .CP_LEN (CP), .TIMEOUT (TO), .TO_W (TOW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .clr_err   (clr_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ld_en     (ld_en),
        .ld_idx    (ld_idx),
        .fft_start (fft_start),
        .fft_done  (fft_done),
        .rd_idx    (rd_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .to_err    (to_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame progress expressed as sample/wait/emit positions.
    int m_loaded = 0;
    bit m_start = 1'b0;
    int m_wait = -1;
    int m_emit = -1;
    bit m_err = 1'b0;
    int m_frames = 0;
    bit m_acc;
    bit m_tmo;
    int m_rd;

    always @(negedge clk) begin
        if (!reset) begin
            m_loaded = 0; m_start = 1'b0; m_wait = -1; m_emit = -1;
            m_err = 1'b0; m_frames = 0;
        end
        m_acc = !m_start && (m_wait < 0) && (m_emit < 0);
        m_rd  = (m_emit < 0) ? 0 : ((m_emit < CP) ? (N - CP + m_emit) : (m_emit - CP));
        chk("in_ready", in_ready, m_acc);
        chk("ld_en", ld_en, in_valid && m_acc);
        chk("ld_idx", ld_idx, m_acc ? m_loaded : 0);
        chk("fft_start", fft_start, m_start);
        chk("out_valid", out_valid, m_emit >= 0);
        chk("rd_idx", rd_idx, m_rd);
        chk("out_last", out_last, m_emit == ELEN - 1);
        chk("busy", busy, (m_loaded > 0) || m_start || (m_wait >= 0) || (m_emit >= 0));
        chk("to_err", to_err, m_err);
        chk("frame_cnt", frame_cnt, m_frames);
        if (reset) begin
            if (flush) begin
                m_loaded = 0; m_start = 1'b0; m_wait = -1; m_emit = -1;
                if (clr_err) m_err = 1'b0;
            end else begin
                m_tmo = 1'b0;
                if (m_acc) begin
                    if (in_valid) begin
                        m_loaded++;
                        if (m_loaded == N) begin
                            m_loaded = 0;
                            m_start = 1'b1;
                        end
                    end
                end else if (m_start) begin
                    m_start = 1'b0;
                    m_wait = 0;
                end else if (m_wait >= 0) begin
                    if (fft_done) begin
                        m_wait = -1;
                        m_emit = 0;
                    end else if (m_wait == TO - 1) begin
                        m_wait = -1;
                        m_tmo = 1'b1;
                    end else begin
                        m_wait++;
                    end
                end else if (out_ready) begin
                    if (m_emit == ELEN - 1) begin
                        m_emit = -1;
                        m_frames = (m_frames + 1) % 65536;
                    end else begin
                        m_emit++;
                    end
                end
                if (m_tmo) m_err = 1'b1;
                else if (clr_err) m_err = 1'b0;
            end
        end
    end

    // Observation records used by the directed literal checks.
    int  rd_q[$];
    bit  last_q[$];
    int  ld_q[$];
    int  ncyc = 0;
    int  start_cnt = 0, start_cyc = 0, last_ld_cyc = 0;
    int  wait_cnt = 0, done_cyc = 0, ov_cyc = 0;
    bit  prev_ov = 1'b0;
    bit  looks_wait;

    always @(negedge clk) begin
        if (reset) begin
            ncyc++;
            if (ld_en) ld_q.push_back(int'(ld_idx));
            if (ld_en && ld_idx == IW'(N - 1)) last_ld_cyc = ncyc;
            if (fft_start) begin
                start_cnt++;
                start_cyc = ncyc;
            end
            if (out_valid && out_ready) begin
                rd_q.push_back(int'(rd_idx));
                last_q.push_back(out_last);
            end
            looks_wait = busy && !in_ready && !fft_start && !out_valid;
            if (looks_wait) wait_cnt++;
            if (looks_wait && fft_done) done_cyc = ncyc;
            if (out_valid && !prev_ov) ov_cyc = ncyc;
            prev_ov = out_valid;
        end
    end

    // Stimulus knobs
    int cyc = 0;
    int since = -1;
    int dly = 3;
    int pv = 100;
    int pr = 100;
    bit gap_mode = 1'b0;
    bit tog_mode = 1'b0;
    bit noise = 1'b0;
    int flush_pct = 0;
    int clr_pct = 0;
    bit flush_req = 1'b0;
    bit clr_req = 1'b0;
    int exp_rd [ELEN] = '{6, 7, 0, 1, 2, 3, 4, 5, 6, 7};

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (fft_start) since = 0;
        else if (since >= 0) since++;
        in_valid  = gap_mode ? (cyc % 3 == 0) : ($urandom_range(0, 99) < pv);
        out_ready = tog_mode ? (cyc % 2 == 1) : ($urandom_range(0, 99) < pr);
        fft_done  = (dly >= 0 && since == dly) || (noise && $urandom_range(0, 19) == 0);
        flush     = flush_req || ($urandom_range(0, 99) < flush_pct);
        clr_err   = clr_req || ($urandom_range(0, 99) < clr_pct);
    endtask

    task automatic clear_obs();
        rd_q.delete();
        last_q.delete();
        ld_q.delete();
        start_cnt = 0;
        wait_cnt = 0;
    endtask

    task automatic wait_frame(input string name, input int budget);
        int fc;
        int g;
        fc = int'(frame_cnt);
        g = 0;
        while (int'(frame_cnt) != (fc + 1) % 65536 && g < budget) begin
            step();
            g++;
        end
        chk(name, frame_cnt, (fc + 1) % 65536);
    endtask

    task automatic check_readout(input string tag);
        chk({tag, "_hs"}, rd_q.size(), ELEN);
        for (int k = 0; k < ELEN; k++) begin
            chk($sformatf("%s_rd%0d", tag, k), (k < rd_q.size()) ? rd_q[k] : -1, exp_rd[k]);
            chk($sformatf("%s_last%0d", tag, k), (k < last_q.size()) ? int'(last_q[k]) : -1,
                (k == ELEN - 1) ? 1 : 0);
        end
    endtask

    task automatic check_load(input string tag);
        chk({tag, "_ld_n"}, ld_q.size(), N);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_ld%0d", tag, k), (k < ld_q.size()) ? ld_q[k] : -1, k);
        end
    endtask

    initial begin
        int g;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fft_start", fft_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_to_err", to_err, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_ld_idx", ld_idx, 0);
        chk("rst_rd_idx", rd_idx, 0);
        chk("rst_ld_en", ld_en, 0);
        reset = 1'b1;

        // Back-to-back frames, done 3 cycles after start
        clear_obs();
        wait_frame("b2b_frame1", 100);
        chk("b2b_frame1_val", frame_cnt, 1);
        check_load("b2b1");
        check_readout("b2b1");
        chk("b2b_start_pulses", start_cnt, 1);
        chk("b2b_start_latency", start_cyc - last_ld_cyc, 1);
        chk("b2b_done_latency", ov_cyc - done_cyc, 1);
        clear_obs();
        wait_frame("b2b_frame2", 100);
        chk("b2b_frame2_val", frame_cnt, 2);
        check_readout("b2b2");

        // Gapped input
        gap_mode = 1'b1;
        clear_obs();
        wait_frame("gap_frame", 200);
        check_load("gap");
        chk("gap_start_pulses", start_cnt, 1);
        chk("gap_start_latency", start_cyc - last_ld_cyc, 1);
        gap_mode = 1'b0;

        // Downstream back-pressure
        tog_mode = 1'b1;
        clear_obs();
        wait_frame("stall_frame", 200);
        check_readout("stall");
        tog_mode = 1'b0;

        // Timeout with done withheld
        dly = -1;
        clear_obs();
        g = int'(frame_cnt);
        for (int i = 0; i < 200 && to_err !== 1'b1; i++) step();
        chk("tmo_to_err", to_err, 1);
        chk("tmo_wait_cycles", wait_cnt, TO);
        chk("tmo_frame_cnt", frame_cnt, g);
        chk("tmo_busy", busy, 0);
        pv = 0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step();
        chk("clr_err_clears", to_err, 0);

        // Done coincident with terminal count
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        pv = 100;
        dly = TO;
        clear_obs();
        wait_frame("coinc_frame", 300);
        chk("coinc_to_err", to_err, 0);
        chk("coinc_wait_cycles", wait_cnt, TO);

        // Flush during load at ld_idx 4
        dly = 3;
        for (int i = 0; i < 50 && ld_idx != IW'(4); i++) step();
        chk("reach_ld4", ld_idx, 4);
        flush = 1'b1;
        step();
        chk("flush_load_busy", busy, 0);
        chk("flush_load_idx", ld_idx, 0);
        clear_obs();
        wait_frame("flush_load_next", 100);
        check_load("flush_load");

        // Flush mid-readout
        for (int i = 0; i < 50 && out_valid !== 1'b1; i++) step();
        chk("reach_emit", out_valid, 1);
        g = int'(frame_cnt);
        repeat (3) step();
        flush = 1'b1;
        step();
        chk("flush_emit_busy", busy, 0);
        chk("flush_emit_valid", out_valid, 0);
        chk("flush_emit_frames", frame_cnt, g);
        clear_obs();
        wait_frame("flush_emit_next", 100);
        check_load("flush_emit");
        check_readout("flush_emit");

        // Asynchronous reset while waiting for the transform
        dly = -1;
        for (int i = 0; i < 50 && !(busy && !in_ready && !fft_start && !out_valid); i++) step();
        chk("reach_wait", busy && !in_ready && !fft_start && !out_valid, 1);
        repeat (5) step();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_fft_start", fft_start, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_last", out_last, 0);
        chk("arst_to_err", to_err, 0);
        chk("arst_frame_cnt", frame_cnt, 0);
        chk("arst_ld_idx", ld_idx, 0);
        chk("arst_rd_idx", rd_idx, 0);
        step();
        step();
        reset = 1'b1;

        // Randomized traffic against the model
        noise = 1'b1;
        flush_pct = 1;
        clr_pct = 2;
        for (int b = 0; b < 15; b++) begin
            pv  = int'($urandom_range(20, 100));
            pr  = int'($urandom_range(20, 100));
            dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 70));
            repeat (200) step();
        end
        noise = 1'b0;
        flush_pct = 0;
        clr_pct = 0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
